// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: IF stage with IF/ID register, single-outstanding imem fetch, bubbles, hold buffer and redirect squash; optional IF_PERF_CNT_EN adds fetch/bubble counters
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_if_i,
  input  logic        busywait_i,
  input  logic        redirect_i,
  input  logic [29:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [29:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [29:0] instr_o,
  output logic [29:0] pc_o,
  output logic        instr_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] fetch_bubble_cnt_o
`endif
);
  typedef enum logic [1:0] {BOOT, REQ, HOLD, DROP} state_t;
  localparam logic [29:0] NOP = NOP_INSTR[31:2];
  state_t state, state_n;
  logic [29:0] fetch_pc_q, fetch_pc_n, drop_addr, drop_addr_n;
  logic [29:0] buf_instr, buf_instr_n, buf_pc, buf_pc_n;
  logic [29:0] instr_n, pc_n;
  logic valid_n, adv, ack, word_ld, bubble_ld;
  logic unused_rdata_lsbs;
  assign unused_rdata_lsbs = ^imem_rdata_i[1:0];
  assign adv = !stall_if_i && !busywait_i && !redirect_i;
  assign imem_req_o = (state == REQ) || (state == DROP);
  // a squashed request keeps its original address until memory answers it
  assign imem_addr_o = (state == DROP) ? drop_addr : fetch_pc_q;
  assign ack = imem_ack_i && imem_req_o;
  // next-state, fetch PC, hold buffer and IF/ID next values
  always_comb begin
    state_n = state;
    fetch_pc_n = fetch_pc_q;
    drop_addr_n = drop_addr;
    buf_instr_n = buf_instr;
    buf_pc_n = buf_pc;
    instr_n = instr_o;
    pc_n = pc_o;
    valid_n = instr_valid_o;
    word_ld = 1'b0;
    bubble_ld = 1'b0;
    if (redirect_i) begin
      fetch_pc_n = redirect_pc_i;
      if (state == DROP) begin
        state_n = ack ? REQ : DROP;
      end else begin
        instr_n = NOP;
        pc_n = '0;
        valid_n = 1'b0;
        buf_instr_n = '0;
        buf_pc_n = '0;
        drop_addr_n = fetch_pc_q;
        state_n = (state == REQ && !ack) ? DROP : REQ;
      end
    end else begin
      case (state)
        BOOT: state_n = REQ;
        REQ: begin
          if (ack && adv) begin
            instr_n = imem_rdata_i[31:2];
            pc_n = fetch_pc_q;
            valid_n = 1'b1;
            fetch_pc_n = fetch_pc_q + 30'd1;
            word_ld = 1'b1;
          end else if (ack) begin
            buf_instr_n = imem_rdata_i[31:2];
            buf_pc_n = fetch_pc_q;
            fetch_pc_n = fetch_pc_q + 30'd1;
            state_n = HOLD;
          end else if (adv) begin
            instr_n = NOP;
            pc_n = '0;
            valid_n = 1'b0;
            bubble_ld = 1'b1;
          end
        end
        HOLD: begin
          if (adv) begin
            instr_n = buf_instr;
            pc_n = buf_pc;
            valid_n = 1'b1;
            buf_instr_n = '0;
            buf_pc_n = '0;
            word_ld = 1'b1;
            state_n = REQ;
          end
        end
        DROP: state_n = ack ? REQ : DROP;
        default: state_n = BOOT;
      endcase
    end
  end
  // state, fetch PC, hold buffer and IF/ID register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= BOOT;
      fetch_pc_q <= RESET_PC[31:2];
      drop_addr <= '0;
      buf_instr <= '0;
      buf_pc <= '0;
      instr_o <= NOP;
      pc_o <= '0;
      instr_valid_o <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc_q <= fetch_pc_n;
      drop_addr <= drop_addr_n;
      buf_instr <= buf_instr_n;
      buf_pc <= buf_pc_n;
      instr_o <= instr_n;
      pc_o <= pc_n;
      instr_valid_o <= valid_n;
    end
  end
`ifdef IF_PERF_CNT_EN
  // wrapping counters of delivered words and memory-wait bubbles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_o <= '0;
      fetch_bubble_cnt_o <= '0;
    end else begin
      fetch_cnt_o <= fetch_cnt_o + {31'd0, word_ld};
      fetch_bubble_cnt_o <= fetch_bubble_cnt_o + {31'd0, bubble_ld};
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = word_ld ^ bubble_ld;
`endif
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: table-driven check of fetch, bubbles, hold, redirect, wrap and async reset
module tb_instruction_fetch_stage;
  localparam logic [29:0] K = 30'h2AAA_0000;
  localparam logic [29:0] NOP = 30'h0000_0004;
  logic clk = 1'b0, rst = 1'b1;
  logic stall = 1'b0, busy = 1'b0, redir = 1'b0, ack = 1'b0;
  logic [29:0] rpc = '0;
  logic [31:0] rdata = '0;
  logic req, valid;
  logic [29:0] addr, instr, pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fcnt, bcnt;
`endif
  int errors = 0, checks = 0;

  instruction_fetch_stage #(.RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
    .clk_i(clk), .rst_i(rst), .stall_if_i(stall), .busywait_i(busy), .redirect_i(redir),
    .redirect_pc_i(rpc), .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
    .imem_rdata_i(rdata), .instr_o(instr), .pc_o(pc), .instr_valid_o(valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt_o(fcnt), .fetch_bubble_cnt_o(bcnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s, b, r;
    logic [29:0] rpc;
    logic a;
    logic [31:0] rd;
    logic req;
    logic [29:0] addr, instr, pc;
    logic valid;
  } vec_t;
  vec_t tbl [27];

  function automatic logic [31:0] d(input logic [29:0] a);
    return {a ^ K, 2'b11};
  endfunction

  function automatic vec_t v(input logic s, b, r, input logic [29:0] rp, input logic a,
      input logic [31:0] rd, input logic rq, input logic [29:0] ad, ins, p, input logic vl);
    vec_t x;
    x.s = s; x.b = b; x.r = r; x.rpc = rp; x.a = a; x.rd = rd;
    x.req = rq; x.addr = ad; x.instr = ins; x.pc = p; x.valid = vl;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, b, r, input logic [29:0] rp, input logic a, input logic [31:0] rd);
    stall = s; busy = b; redir = r; rpc = rp; ack = a; rdata = rd;
  endtask

  initial begin
    tbl[0]  = v(0,0,0,0,1,0,          0,30'h40, NOP,0,0);
    tbl[1]  = v(0,0,0,0,1,d(30'h40),  1,30'h40, 30'h40^K,30'h40,1);
    tbl[2]  = v(0,0,0,0,1,d(30'h41),  1,30'h41, 30'h41^K,30'h41,1);
    tbl[3]  = v(0,0,0,0,1,d(30'h42),  1,30'h42, 30'h42^K,30'h42,1);
    tbl[4]  = v(0,0,0,0,0,0,          1,30'h43, NOP,0,0);
    tbl[5]  = v(0,0,0,0,0,0,          1,30'h43, NOP,0,0);
    tbl[6]  = v(0,0,0,0,0,0,          1,30'h43, NOP,0,0);
    tbl[7]  = v(0,0,0,0,1,d(30'h43),  1,30'h43, 30'h43^K,30'h43,1);
    tbl[8]  = v(1,0,0,0,1,d(30'h44),  1,30'h44, 30'h43^K,30'h43,1);
    tbl[9]  = v(1,0,0,0,1,32'hFFFF_FFFF, 0,30'h45, 30'h43^K,30'h43,1);
    tbl[10] = v(0,0,0,0,1,32'hFFFF_FFFF, 0,30'h45, 30'h44^K,30'h44,1);
    tbl[11] = v(0,0,0,0,1,d(30'h45),  1,30'h45, 30'h45^K,30'h45,1);
    tbl[12] = v(0,1,0,0,0,0,          1,30'h46, 30'h45^K,30'h45,1);
    tbl[13] = v(0,0,1,30'h80,0,0,     1,30'h46, NOP,0,0);
    tbl[14] = v(0,0,0,0,0,d(30'h46),  1,30'h46, NOP,0,0);
    tbl[15] = v(0,0,0,0,1,32'hDEAD_BEEF, 1,30'h46, NOP,0,0);
    tbl[16] = v(0,0,0,0,1,d(30'h80),  1,30'h80, 30'h80^K,30'h80,1);
    tbl[17] = v(1,0,0,0,1,d(30'h81),  1,30'h81, 30'h80^K,30'h80,1);
    tbl[18] = v(1,1,1,30'h90,1,32'hFFFF_FFFF, 0,30'h82, NOP,0,0);
    tbl[19] = v(0,0,0,0,1,d(30'h90),  1,30'h90, 30'h90^K,30'h90,1);
    tbl[20] = v(0,0,1,30'h3FFF_FFFF,1,d(30'h91), 1,30'h91, NOP,0,0);
    tbl[21] = v(0,0,0,0,1,d(30'h3FFF_FFFF), 1,30'h3FFF_FFFF, 30'h3FFF_FFFF^K,30'h3FFF_FFFF,1);
    tbl[22] = v(0,0,0,0,1,d(30'h0),   1,30'h0, K,30'h0,1);
    tbl[23] = v(0,0,1,30'h50,0,0,     1,30'h1, NOP,0,0);
    tbl[24] = v(0,0,1,30'h60,0,0,     1,30'h1, NOP,0,0);
    tbl[25] = v(0,0,0,0,1,32'hFFFF_FFFF, 1,30'h1, NOP,0,0);
    tbl[26] = v(0,0,0,0,1,d(30'h60),  1,30'h60, 30'h60^K,30'h60,1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset req", {31'd0, req}, 32'd0);
    chk("reset addr", {2'b0, addr}, 32'h40);
    chk("reset instr", {2'b0, instr}, {2'b0, NOP});
    chk("reset pc", {2'b0, pc}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].s, tbl[i].b, tbl[i].r, tbl[i].rpc, tbl[i].a, tbl[i].rd);
      #2;
      chk($sformatf("step%0d req", i), {31'd0, req}, {31'd0, tbl[i].req});
      chk($sformatf("step%0d addr", i), {2'b0, addr}, {2'b0, tbl[i].addr});
      @(posedge clk);
      #1;
      chk($sformatf("step%0d instr", i), {2'b0, instr}, {2'b0, tbl[i].instr});
      chk($sformatf("step%0d pc", i), {2'b0, pc}, {2'b0, pc_o_exp(i)});
      chk($sformatf("step%0d valid", i), {31'd0, valid}, {31'd0, tbl[i].valid});
    end

    drive(0,0,0,0,0,0);
    #2;
    chk("wait req", {31'd0, req}, 32'd1);
    chk("wait addr", {2'b0, addr}, 32'h61);
    rst = 1'b1;
    #1;
    chk("async req", {31'd0, req}, 32'd0);
    chk("async addr", {2'b0, addr}, 32'h40);
    chk("async instr", {2'b0, instr}, {2'b0, NOP});
    chk("async valid", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0,0,0,0,1,d(30'h40));
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      drive(0,0,0,0,1,d(30'h40 + 30'(i)));
      @(posedge clk);
    end
    #1;
    chk("perf last pc", {2'b0, pc}, 32'h44);
    chk("perf last instr", {2'b0, instr}, {2'b0, 30'h44 ^ K});
    drive(0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    chk("perf bubble valid", {31'd0, valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fcnt, 32'd5);
    chk("bubble_cnt", bcnt, 32'd2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [29:0] pc_o_exp(input int i);
    return tbl[i].pc;
  endfunction
endmodule
